// File: rtl/bus_arb_mux.sv
// N-channel arbitrating mux with a single-entry registered output and valid/ready
// handshakes. MODE=0 picks the channel from sel_i; MODE=1 round-robins over valid channels.
module bus_arb_mux #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CH*WIDTH-1:0] in_data_i,
    input  logic [CH-1:0]       in_valid_i,
    output logic [CH-1:0]       in_ready_o,
    input  logic [SELW-1:0]     sel_i,
    output logic [WIDTH-1:0]    out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [SELW-1:0]     out_ch_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             can_accept;
    logic [SELW-1:0]  grant;
    logic             grant_hit;
    logic             gvalid;
    logic [WIDTH-1:0] grant_data;
    logic             xfer_in;

    assign can_accept = !valid_q || out_ready_i;

    // grant_hit: grant names a real channel (sel in range, or some channel valid in RR)
    always_comb begin
        int best;
        int off;
        grant     = '0;
        grant_hit = 1'b0;
        gvalid    = 1'b0;
        best      = CH;
        off       = 0;
        if (MODE == 0) begin
            grant = sel_i;
            for (int i = 0; i < CH; i++) begin
                if (sel_i == SELW'(i)) begin
                    grant_hit = 1'b1;
                    gvalid    = in_valid_i[i];
                end
            end
        end else begin
            // Distance of each valid channel from ptr, wrapping at CH; nearest wins.
            for (int i = 0; i < CH; i++) begin
                off = i - int'(ptr_q);
                if (off < 0) off = off + CH;
                if (in_valid_i[i] && off < best) begin
                    best      = off;
                    grant     = SELW'(i);
                    grant_hit = 1'b1;
                    gvalid    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready_o = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant == SELW'(i)) begin
                grant_data    = in_data_i[i*WIDTH +: WIDTH];
                in_ready_o[i] = grant_hit && can_accept && !rst_i;
            end
        end
    end

    assign xfer_in = gvalid && can_accept && !rst_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (xfer_in) begin
            data_d  = grant_data;
            ch_d    = grant;
            valid_d = 1'b1;
            if (MODE != 0) begin
                ptr_d = (grant == SELW'(CH-1)) ? '0 : grant + 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_ch_o    = ch_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Four bus_arb_mux instances (fixed/RR x CH=4/CH=3) driven by directed and random
// stimulus and compared every cycle against a transaction-level model.
module tb_bus_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        drv_rst  [4];
    logic [3:0]  drv_v    [4];
    logic [1:0]  drv_sel  [4];
    logic        drv_ordy [4];
    logic [63:0] drv_data [4];

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2, rdy3;
    logic [15:0] od [4];
    logic        ov [4];
    logic [1:0]  oc [4];

    bus_arb_mux #(.WIDTH(16), .CH(4), .SELW(2), .MODE(0)) u_fix4 (
        .clk_i(clk), .rst_i(drv_rst[0]), .in_data_i(drv_data[0]), .in_valid_i(drv_v[0]),
        .in_ready_o(rdy0), .sel_i(drv_sel[0]), .out_data_o(od[0]), .out_valid_o(ov[0]),
        .out_ready_i(drv_ordy[0]), .out_ch_o(oc[0]));
    bus_arb_mux #(.WIDTH(16), .CH(4), .SELW(2), .MODE(1)) u_rr4 (
        .clk_i(clk), .rst_i(drv_rst[1]), .in_data_i(drv_data[1]), .in_valid_i(drv_v[1]),
        .in_ready_o(rdy1), .sel_i(drv_sel[1]), .out_data_o(od[1]), .out_valid_o(ov[1]),
        .out_ready_i(drv_ordy[1]), .out_ch_o(oc[1]));
    bus_arb_mux #(.WIDTH(16), .CH(3), .SELW(2), .MODE(1)) u_rr3 (
        .clk_i(clk), .rst_i(drv_rst[2]), .in_data_i(drv_data[2][47:0]), .in_valid_i(drv_v[2][2:0]),
        .in_ready_o(rdy2), .sel_i(drv_sel[2]), .out_data_o(od[2]), .out_valid_o(ov[2]),
        .out_ready_i(drv_ordy[2]), .out_ch_o(oc[2]));
    bus_arb_mux #(.WIDTH(16), .CH(3), .SELW(2), .MODE(0)) u_fix3 (
        .clk_i(clk), .rst_i(drv_rst[3]), .in_data_i(drv_data[3][47:0]), .in_valid_i(drv_v[3][2:0]),
        .in_ready_o(rdy3), .sel_i(drv_sel[3]), .out_data_o(od[3]), .out_valid_o(ov[3]),
        .out_ready_i(drv_ordy[3]), .out_ch_o(oc[3]));

    int n_chk = 0;
    int n_err = 0;

    // Model state: output register contents and RR pointer per instance
    int          m_ov [4];
    logic [15:0] m_od [4];
    int          m_oc [4];
    int          m_ptr[4];
    int          n_ov [4];
    logic [15:0] n_od [4];
    int          n_oc [4];
    int          n_ptr[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nch(input int k);
        return (k < 2) ? 4 : 3;
    endfunction

    function automatic int rr_mode(input int k);
        return (k == 1 || k == 2) ? 1 : 0;
    endfunction

    // Channel the arbiter points at this cycle, or -1 when no channel can be granted
    function automatic int pick(input int k);
        int n = nch(k);
        if (rr_mode(k) == 0) return (int'(drv_sel[k]) < n) ? int'(drv_sel[k]) : -1;
        for (int off = 0; off < n; off++) begin
            int c = (m_ptr[k] + off) % n;
            if (drv_v[k][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(input int k);
        int g;
        if (drv_rst[k]) return 4'b0;
        if (m_ov[k] != 0 && !drv_ordy[k]) return 4'b0;
        g = pick(k);
        if (g < 0) return 4'b0;
        return 4'(1 << g);
    endfunction

    function automatic logic [3:0] get_rdy(input int k);
        case (k)
            0: return rdy0;
            1: return rdy1;
            2: return {1'b0, rdy2};
            default: return {1'b0, rdy3};
        endcase
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 4; k++) begin
            drv_rst[k]  = 1'b0;
            drv_v[k]    = 4'b0;
            drv_sel[k]  = 2'd0;
            drv_ordy[k] = 1'b1;
            drv_data[k] = 64'h0;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        #1;
        for (int k = 0; k < 4; k++) begin
            int  g;
            bit  can;
            chk($sformatf("in_ready[%0d]", k), 64'(get_rdy(k)), 64'(exp_rdy(k)));
            n_ov[k] = m_ov[k]; n_od[k] = m_od[k]; n_oc[k] = m_oc[k]; n_ptr[k] = m_ptr[k];
            if (drv_rst[k]) begin
                n_ov[k] = 0; n_od[k] = 16'h0; n_oc[k] = 0; n_ptr[k] = 0;
            end else begin
                can = (m_ov[k] == 0) || drv_ordy[k];
                g   = pick(k);
                if (can && g >= 0 && drv_v[k][g]) begin
                    n_ov[k] = 1;
                    n_od[k] = drv_data[k][g*16 +: 16];
                    n_oc[k] = g;
                    if (rr_mode(k) != 0) n_ptr[k] = (g + 1) % nch(k);
                end else if (m_ov[k] != 0 && drv_ordy[k]) begin
                    n_ov[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            m_ov[k] = n_ov[k]; m_od[k] = n_od[k]; m_oc[k] = n_oc[k]; m_ptr[k] = n_ptr[k];
            chk($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(m_ov[k]));
            chk($sformatf("out_data[%0d]", k), 64'(od[k]), 64'(m_od[k]));
            chk($sformatf("out_ch[%0d]", k), 64'(oc[k]), 64'(m_oc[k]));
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_ov[k] = 0; m_od[k] = 16'h0; m_oc[k] = 0; m_ptr[k] = 0;
        end
        idle_all();
        for (int k = 0; k < 4; k++) drv_rst[k] = 1'b1;
        @(negedge clk);
        step();
        step();
        idle_all();

        // Reset while a word is stalled in the output register
        drv_sel[0] = 2'd2; drv_v[0] = 4'b0100; drv_data[0] = 64'h0000_A5A5_0000_0000; drv_ordy[0] = 1'b0;
        step();
        chk("t1_load", 64'(od[0]), 64'hA5A5);
        drv_v[0] = 4'b0;
        step();
        drv_rst[0] = 1'b1;
        #1 chk("t1_rdy_in_rst", 64'(rdy0), 64'h0);
        step();
        chk("t1_ov_after_rst", 64'(ov[0]), 64'h0);
        chk("t1_od_after_rst", 64'(od[0]), 64'h0);
        chk("t1_oc_after_rst", 64'(oc[0]), 64'h0);
        drv_rst[0] = 1'b0; drv_ordy[0] = 1'b1;

        // Fixed-select streaming on ch1
        drv_sel[0] = 2'd1;
        for (int j = 1; j <= 3; j++) begin
            drv_v[0] = 4'b0010; drv_data[0] = 64'(j) << 16;
            #1 chk("t2_rdy", 64'(rdy0), 64'h2);
            step();
            chk("t2_data", 64'(od[0]), 64'(j));
            chk("t2_ch", 64'(oc[0]), 64'h1);
        end
        drv_v[0] = 4'b0;
        step();

        // Backpressure with sel changed mid-stall
        drv_sel[0] = 2'd3; drv_v[0] = 4'b1001; drv_data[0] = 64'hBEEF_0000_0000_1234; drv_ordy[0] = 1'b0;
        step();
        drv_sel[0] = 2'd0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t3_hold", 64'(od[0]), 64'hBEEF);
            chk("t3_rdy_stall", 64'(rdy0), 64'h0);
        end
        drv_ordy[0] = 1'b1;
        step();
        chk("t3_next_data", 64'(od[0]), 64'h1234);
        chk("t3_next_ch", 64'(oc[0]), 64'h0);
        idle_all();

        // Round-robin fairness, all channels valid
        drv_rst[1] = 1'b1;
        step();
        drv_rst[1] = 1'b0; drv_v[1] = 4'b1111; drv_data[1] = 64'h0030_0020_0010_0000;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("t4_ch", 64'(oc[1]), 64'(j % 4));
            chk("t4_data", 64'(od[1]), 64'((j % 4) * 16));
        end
        idle_all();

        // Round-robin skip and wrap on CH=3
        drv_rst[2] = 1'b1;
        step();
        drv_rst[2] = 1'b0; drv_data[2] = 64'h0000_00C2_00B1_00A0; drv_v[2] = 4'b0010;
        step();
        drv_v[2] = 4'b0011;
        step();
        chk("t5_wrap_ch0", 64'(oc[2]), 64'h0);
        step();
        chk("t5_then_ch1", 64'(oc[2]), 64'h1);
        idle_all();

        // Out-of-range select on CH=3
        drv_rst[3] = 1'b1;
        step();
        drv_rst[3] = 1'b0; drv_sel[3] = 2'd3; drv_v[3] = 4'b0111; drv_data[3] = 64'h0000_3333_2222_1111;
        for (int j = 0; j < 3; j++) begin
            #1 chk("t6_rdy", 64'(rdy3), 64'h0);
            step();
            chk("t6_no_valid", 64'(ov[3]), 64'h0);
        end
        idle_all();

        // Random traffic on all instances
        for (int j = 0; j < 500; j++) begin
            for (int k = 0; k < 4; k++) begin
                drv_rst[k]  = ($urandom % 40) == 0;
                drv_v[k]    = 4'($urandom);
                drv_sel[k]  = 2'($urandom);
                drv_ordy[k] = ($urandom % 4) != 0;
                drv_data[k] = {$urandom, $urandom};
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
- Parametrised N-channel successor to the processor's 2:1 datapath select mux. It adds a registered output, a valid/ready handshake per channel, and a selectable arbitration mode.
- It sits between multiple bus sources (register file ports, ALU result, immediate, memory read data) and a single consumer such as the write-back or bus driver.
- It supplies one WIDTH-bit word per transfer and tags each word with the channel it came from.

Parameters:
- WIDTH, 16, data word width in bits.
- CH, 4, number of input channels; legal range 2..16.
- SELW, 2, width of the channel index. Must equal ceil(log2(CH)), and must be 1 when CH=2.
- MODE, 0, arbitration mode.
  - 0 = fixed: channel chosen by the sel input.
  - 1 = round-robin among valid channels.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- in_data, input, CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, CH: per-channel word-available flag.
- in_ready, output, CH: per-channel accept flag; combinational.
- sel, input, SELW: channel index; used only when MODE=0.
- out_data, output, WIDTH: registered output word.
- out_valid, output, 1: registered flag; out_data holds a word.
- out_ready, input, 1: consumer accepts the current word.
- out_ch, output, SELW: registered index of the channel that supplied out_data.

Behaviour:

Reset:
- rst is sampled on the clk edge only. It has priority over every other event.
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
- A word held in the output register is discarded on reset. in_ready is 0 for all channels during a cycle in which rst=1.

Output register:
- The output register is a single-entry buffer.
- can_accept = !out_valid | out_ready.

Grant selection (combinational, each cycle):
- MODE=0:
  - grant = sel.
  - gvalid = in_valid[sel].
  - sel >= CH gives gvalid=0, and no channel is ready.
- MODE=1:
  - grant = the first i with in_valid[i]=1, scanning ptr, ptr+1, … CH-1, 0, … ptr-1 (wrapping at CH, not at 2^SELW).
  - gvalid = |in_valid.

Ready and transfer:
- in_ready[i] = (i==grant) & can_accept & !rst. In MODE=0, the granted channel sees in_ready high even if in_valid is low.
- An input transfer happens when in_valid[grant] & in_ready[grant].
  - On that clk edge: out_data <= the granted word, out_ch <= grant, out_valid <= 1.
  - In MODE=1 only: ptr <= (grant==CH-1) ? 0 : grant+1.
- An output transfer happens when out_valid & out_ready.
  - If no input transfer occurs on the same edge, out_valid <= 0.
  - out_data and out_ch keep their last values.

Timing:
- Latency is 1 cycle from the input transfer to out_valid.
- Throughput is one word per cycle when out_ready is held at 1. A simultaneous output and input transfer replaces the register contents with no bubble.

Backpressure:
- While out_valid=1 and out_ready=0: out_data, out_valid and out_ch are held stable, all in_ready=0, and ptr is unchanged.
- Changing sel or in_valid during a stall has no effect on the held word.
- ptr advances only on an input transfer, never on idle cycles.

Other rules:
- No combinational path from in_data to out_data.
- in_ready depends on out_ready, in_valid (MODE=1), sel (MODE=0), out_valid and rst only.
- Channels that are not granted see in_ready=0 and must hold their words.

Test Plan:
1. Reset mid-stall: MODE=0, load word 16'hA5A5 on ch 2 with out_ready=0, then assert rst for one cycle -> out_valid=0, out_data=16'h0000, out_ch=0 the cycle after, and in_ready=4'b0000 during the rst cycle.
2. Fixed select streaming: MODE=0, sel=1, ch1 presents 16'h0001, 16'h0002, 16'h0003 back-to-back with out_ready=1 -> out_data shows 0001, 0002, 0003 on three consecutive cycles, each 1 cycle after its input; out_ch=1; in_ready=4'b0010 throughout.
3. Backpressure: MODE=0, sel=3, ch3 presents 16'hBEEF, out_ready=0 for 3 cycles, sel switched to 0 during the stall -> out_data=16'hBEEF held stable, in_ready=0 during the stall. On out_ready=1, the word is consumed and ch0 is granted next.
4. Round-robin fairness: MODE=1, all four channels valid continuously, with channel i presenting 16'h00i0, out_ready=1 -> out_ch sequence 0, 1, 2, 3, 0, 1 and out_data 0000, 0010, 0020, 0030, 0000, 0010.
5. Round-robin skip and wrap: MODE=1, CH=3, SELW=2, ptr at 2, only ch0 and ch1 valid -> ch0 granted, then ch1. The pointer wraps from 2 to 0 and never indexes 3.
6. Invalid select: MODE=0, CH=3, sel=3, all valid -> in_ready=0, out_valid stays 0, and no transfer occurs.
